acp_pwm_dac: RTL and testbench

Audio output stage directly downstream of the audio copper (ACP). Accepts 8-bit unsigned PCM samples over a valid/ready handshake and buffers them in a small FIFO. Releases one sample per sample-rate tick and converts it to a single-bit PWM stream for the board's audio pin. Reports FIFO underruns through a sticky flag so software and the testbench can detect starvation.

---
 rtl/acp_audio_pkg.sv | 16 +
 rtl/acp_sample_fifo.sv | 63 ++++++
 rtl/acp_pwm_dac.sv | 88 ++++++++
 tb/tb_acp_pwm_dac.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/acp_audio_pkg.sv
// Shared audio-path constants and helpers for the ACP output stage.
package acp_audio_pkg;

  localparam int unsigned SAMPLE_W_DEF   = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned SAMPLE_DIV_DEF = 1024;

  // Midscale PCM value: a 50% duty PWM, heard as silence.
  localparam logic [7:0] SILENCE = 8'h80;

  // Occupancy counters need one extra bit to represent "full".
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acp_sample_fifo.sv
// Synchronous sample FIFO with occupancy counter; ready depends only on the registered level.
module acp_sample_fifo
  import acp_audio_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_W_DEF,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_empty,
  output logic                       o_ready,
  output logic [level_w(DEPTH)-1:0]  o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_ready = !w_full;
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !w_full;
  assign w_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the level counter alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/acp_pwm_dac.sv
// ACP audio output: sample FIFO, sample-rate divider, period-aligned duty update, PWM and underrun flag.
module acp_pwm_dac
  import acp_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic                            clk50MHz,
  input  logic                            rst,
  input  logic [SAMPLE_W-1:0]             sample_in,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  input  logic                            underrun_clr,
  output logic                            pwm_out,
  output logic                            underrun,
  output logic [level_w(FIFO_DEPTH)-1:0]  fifo_level
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(SILENCE);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [SAMPLE_W-1:0] r_pwm_cnt;
  logic [SAMPLE_W-1:0] r_duty;
  logic [SAMPLE_W-1:0] r_duty_next;
  logic                r_pwm_out;
  logic                r_underrun;

  logic                w_tick;
  logic                w_fifo_empty;
  logic [SAMPLE_W-1:0] w_fifo_head;

  acp_sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk50MHz),
    .i_rst       (rst),
    .i_push      (sample_valid),
    .i_push_data (sample_in),
    .i_pop       (w_tick),
    .o_head      (w_fifo_head),
    .o_empty     (w_fifo_empty),
    .o_ready     (sample_ready),
    .o_level     (fifo_level)
  );

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
    end
  end

  // An empty tick repeats the previous sample rather than dropping to silence.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_duty_next <= MIDSCALE;
      r_underrun  <= 1'b0;
    end else begin
      if (w_tick && !w_fifo_empty) r_duty_next <= w_fifo_head;
      if (w_tick && w_fifo_empty)  r_underrun  <= 1'b1;
      else if (underrun_clr)       r_underrun  <= 1'b0;
    end
  end

  // Duty is only reloaded on the last count of a period, so no period is ever truncated.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= MIDSCALE;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (&r_pwm_cnt) r_duty <= r_duty_next;
      r_pwm_out <= (r_pwm_cnt < r_duty);
    end
  end

  assign pwm_out  = r_pwm_out;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_acp_pwm_dac.sv
// Directed bench for acp_pwm_dac: edges are counted from reset release, so tick and period boundaries are known.
module tb_acp_pwm_dac;

  logic       clk50MHz;
  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       underrun_clr;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int h;

  acp_pwm_dac dut (
    .clk50MHz     (clk50MHz),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .pwm_out      (pwm_out),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk50MHz = 1'b0;
  always #5 clk50MHz = ~clk50MHz;

  // Edges since reset release: after edge k, pwm_cnt = k mod 256 and div_cnt = k mod 1024.
  always @(posedge clk50MHz) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge following post-reset edge 'target'.
  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target) begin
      @(negedge clk50MHz);
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_cyc: cycle=%0d required=%0d", cyc, target);
        $fatal(1, "cycle counter stalled");
      end
    end
  endtask

  // High cycles of PWM period m (pwm_cnt 0..255 seen after edges 256m+1 .. 256m+256).
  task automatic measure(input int m, output int high);
    wait_cyc(256 * m);
    high = 0;
    repeat (256) begin
      @(negedge clk50MHz);
      high += int'(pwm_out);
    end
  endtask

  task automatic push_at(input int edge_no, input logic [7:0] d);
    wait_cyc(edge_no - 1);
    sample_valid = 1'b1;
    sample_in    = d;
    @(negedge clk50MHz);
    sample_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;

    // Reset
    repeat (3) @(negedge clk50MHz);
    check("rst_ready", sample_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_pwm", pwm_out, 0);
    rst = 1'b0;

    measure(0, h);
    check("midscale_high", h, 128);

    // Fill with no tick in between, then offer a fifth sample
    push_at(257, 8'h10);
    push_at(258, 8'h20);
    push_at(259, 8'h30);
    push_at(260, 8'h40);
    check("full_level", fifo_level, 4);
    check("full_ready", sample_ready, 0);
    push_at(261, 8'h99);
    check("fifth_rejected_level", fifo_level, 4);

    // Drain: tick k at edge 1024k; sample popped at tick k drives periods 4k+1..4k+4
    wait_cyc(1024);
    check("pop1_level", fifo_level, 3);
    check("pop1_ready", sample_ready, 1);
    measure(4, h);
    check("pre_apply_high", h, 128);
    measure(5, h);
    check("duty_0x10_high", h, 16);
    measure(9, h);
    check("duty_0x20_high", h, 32);
    measure(13, h);
    check("duty_0x30_high", h, 48);
    wait_cyc(4096);
    check("drained_level", fifo_level, 0);
    check("no_underrun_yet", underrun, 0);
    measure(17, h);
    check("duty_0x40_high", h, 64);

    // Underrun on an empty tick at edge 5120
    wait_cyc(5119);
    check("underrun_before_tick", underrun, 0);
    wait_cyc(5120);
    check("underrun_set", underrun, 1);
    wait_cyc(5200);
    check("underrun_sticky", underrun, 1);
    measure(21, h);
    check("repeat_last_high", h, 64);
    underrun_clr = 1'b1;
    @(negedge clk50MHz);
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);

    // Clear coinciding with an empty tick: set wins
    wait_cyc(6143);
    underrun_clr = 1'b1;
    @(negedge clk50MHz);
    underrun_clr = 1'b0;
    check("set_beats_clear", underrun, 1);
    underrun_clr = 1'b1;
    @(negedge clk50MHz);
    underrun_clr = 1'b0;
    check("underrun_cleared2", underrun, 0);

    // Simultaneous push and pop with level 2
    push_at(6200, 8'hA1);
    push_at(6201, 8'hA2);
    check("two_level", fifo_level, 2);
    push_at(7168, 8'h55);
    check("push_pop_level", fifo_level, 2);
    measure(29, h);
    check("older_head_popped", h, 32'hA1);
    wait_cyc(8192);
    check("level_after_pop2", fifo_level, 1);
    measure(33, h);
    check("second_entry_high", h, 32'hA2);
    wait_cyc(9216);
    check("level_after_pop3", fifo_level, 0);
    measure(37, h);
    check("tail_0x55_high", h, 32'h55);
    check("no_underrun_while_fed", underrun, 0);

    // Extremes: 0x00 popped at 10240, 0xFF at 11264
    push_at(9800, 8'h00);
    push_at(9801, 8'hFF);
    for (int m = 41; m < 45; m++) begin
      measure(m, h);
      check($sformatf("zero_duty_p%0d", m), h, 0);
    end
    measure(45, h);
    check("full_duty_p45", h, 255);
    measure(46, h);
    check("full_duty_p46", h, 255);
    wait_cyc(12287);
    check("underrun_pre_tick2", underrun, 0);
    wait_cyc(12288);
    check("underrun_set2", underrun, 1);
    measure(49, h);
    check("hold_0xff_p49", h, 255);

    // Mid-operation reset with a push presented during reset
    push_at(12810, 8'h33);
    check("pre_reset_level", fifo_level, 1);
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'h77;
    repeat (2) @(negedge clk50MHz);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_pwm", pwm_out, 0);
    rst          = 1'b0;
    sample_valid = 1'b0;
    measure(0, h);
    check("post_rst_midscale", h, 128);
    check("post_rst_level", fifo_level, 0);
    wait_cyc(1023);
    check("post_rst_no_underrun", underrun, 0);
    wait_cyc(1024);
    check("post_rst_underrun", underrun, 1);
    measure(5, h);
    check("post_rst_duty_next_mid", h, 128);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
